line_window_ctrl: RTL and testbench
===================================

Name: line_window_ctrl

Overview:
- Controller for the RAM line-tap delay lines in the Video_Image_Processor operation chain.
- Consumes a raster pixel stream (vsync/href/clken/data) and sequences two H_ACTIVE-deep line taps, one clock-enable per accepted pixel.
- Assembles a 3x3 neighbourhood, tracks frame, row and column position, and flags border and incomplete windows.
- Polices line length and frame sync so downstream filters (Sobel, median, mean) only consume aligned windows.

Parameters:
- H_ACTIVE, 640, active pixels per line; also the Delay_Length of each line tap.
- V_ACTIVE, 480, active lines per frame.
- DATA_WIDTH, 8, pixel width.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- per_frame_vsync  in  1  frame sync, active high.
- per_frame_href  in  1  line active.
- per_frame_clken  in  1  pixel strobe; a pixel is accepted when href && clken.
- per_img_data  in  DATA_WIDTH  input pixel.
- post_frame_vsync  out  1  per_frame_vsync delayed by LAT.
- post_frame_href  out  1  per_frame_href delayed by LAT.
- post_frame_clken  out  1  window strobe, one per accepted pixel.
- matrix_p11..matrix_p33  out  DATA_WIDTH each  3x3 window; p11 oldest row and column, p33 the current pixel.
- win_x  out  16  column of the window centre (current column - 1).
- win_y  out  16  row of the window centre (current row - 1).
- win_border  out  1  window touches an image edge or includes stale line-tap data.
- line_err  out  1  sticky; a line length was not H_ACTIVE. Cleared on the next vsync rising edge.

Behaviour:
- Reset: all outputs 0, FSM = IDLE, col_cnt = row_cnt = 0. Line-tap RAM contents are not reset; validity comes only from counters.
- FSM states:
  - IDLE: after reset. On the vsync rising edge -> WAIT_LINE.
  - WAIT_LINE: href rising -> ACTIVE; row_cnt == V_ACTIVE -> FRAME_END.
  - ACTIVE: href falling -> WAIT_LINE, checking the line length (see below).
  - FRAME_END: ignores href. On the vsync rising edge -> WAIT_LINE.
  - ERROR: entered on a length error. On the vsync rising edge -> WAIT_LINE.
  - Vsync rising edge in any state -> WAIT_LINE and clears col_cnt, row_cnt and line_err.
- Pixel acceptance: only in ACTIVE with href && clken. Tap clken is asserted in exactly those cycles.
- Tap chain: tap0.shiftin = per_img_data; tap1.shiftin = tap0.shiftout. Row column = {tap1.out, tap0.out, data} for rows 1..3.
- Column shift: on each accepted pixel, p*1 <= p*2, p*2 <= p*3, and p*3 <= the new row column.
- Latency: LAT = 1 clock.
  - Window registers, post_frame_clken, win_x/win_y and win_border update on the clock edge that accepts the pixel.
  - post_frame_vsync/href are delayed 1 clock to match.
- Counters:
  - col_cnt increments per accepted pixel.
  - On href falling, col_cnt resets to 0 and row_cnt increments, saturating at V_ACTIVE.
- Window position: win_x = col_cnt - 1, win_y = row_cnt - 1, computed with the pre-increment counts and wrapping mod 2^16.
- win_border = 1 when any of these hold: col_cnt < 2, row_cnt < 2, col_cnt == H_ACTIVE - 1, or the window was formed in ERROR.
- Length check (at href falling):
  - If col_cnt != H_ACTIVE: line_err <= 1 and FSM -> ERROR.
  - Pixels after the H_ACTIVE-th in a line are not accepted (no tap clken), so tap alignment is preserved.
- ERROR state: taps are still clocked per accepted pixel, outputs still strobe, and win_border is forced to 1.
- FRAME_END: accepts no pixels, so no post_frame_clken pulses occur.
- Reset mid-line: clears all state. The first frame after reset starts only on a vsync rising edge; any partial frame before it is ignored.

Decomposition:
- Package line_window_pkg: FSM state enum (IDLE, WAIT_LINE, ACTIVE, FRAME_END, ERROR) and a COORD_W = 16 constant.
- Sub-modules: two instances of RAMshift_taps (Delay_Length = H_ACTIVE, INPUT_WIDTH = DATA_WIDTH).
- The controller FSM, counters and window registers live in line_window_ctrl itself.

Test Plan (H_ACTIVE=8, V_ACTIVE=4, pixel value = 16*row + col):
- Scenario 1, reset mid-frame: assert rst_n = 0 at row 2, col 3 -> all outputs 0 and no post_frame_clken until a vsync rising edge; the next frame is windowed correctly.
- Scenario 2, full frame, continuous clken: at input row 2, col 2 -> p11 = 0x00, p22 = 0x11, p33 = 0x22, win_x = 1, win_y = 1, win_border = 0. Exactly 32 post_frame_clken pulses per frame.
- Scenario 3, gapped clken (every other cycle): windows must match Scenario 2 values exactly; post_frame_clken pulses 1 cycle after each accepted pixel.
- Scenario 4, line 1 carries only 6 pixels: line_err = 1 and FSM = ERROR; every later window that frame has win_border = 1; the next vsync clears line_err.
- Scenario 5, line 2 carries 10 pixels: only 8 pixels reach the taps, line_err = 1, and row 3 windows still show column alignment (p23 = 0x23 at row 3, col 3).
- Scenario 6, extra 5th href after V_ACTIVE lines: FSM stays in FRAME_END and no post_frame_clken pulses occur.

Source files
------------

// File: rtl/line_window_pkg.sv
// Shared types and constants for the line-window controller.
package line_window_pkg;

   localparam int COORD_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_LINE,
      ACTIVE,
      FRAME_END,
      ERROR
   } state_e;

endpackage

// File: rtl/RAMshift_taps.sv
// Single-tap line delay: shiftout is the sample written Delay_Length enables ago.
// Storage is not reset; only the circular pointer is.
module RAMshift_taps #(
   parameter int Delay_Length = 640,
   parameter int INPUT_WIDTH  = 8
) (
   input  logic                   clock,
   input  logic                   rst_n,
   input  logic                   clken,
   input  logic [INPUT_WIDTH-1:0] shiftin,
   output logic [INPUT_WIDTH-1:0] shiftout
);

   localparam int PTR_W = (Delay_Length > 1) ? $clog2(Delay_Length) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(Delay_Length - 1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [INPUT_WIDTH-1:0] mem_q [Delay_Length];
   logic [PTR_W-1:0]       ptr_q;
   logic [PTR_W-1:0]       ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (clken) begin
         ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   // Read-before-write at the same slot gives exactly Delay_Length of delay.
   always_ff @(posedge clock) begin
      if (clken) begin
         mem_q[ptr_q] <= shiftin;
      end
   end

   assign shiftout = mem_q[ptr_q];

endmodule

// File: rtl/line_window_ctrl.sv
// Raster line-window controller: drives two line taps, assembles a 3x3 window
// and reports its position, border status and line-length errors.
//
// state     | meaning
// IDLE      | after reset, waiting for the first vsync rising edge
// WAIT_LINE | between lines, waiting for href to rise
// ACTIVE    | inside a line, accepting pixels
// FRAME_END | V_ACTIVE lines done, href ignored until next vsync
// ERROR     | a line had the wrong length; windows still strobe, flagged border
module line_window_ctrl
   import line_window_pkg::*;
#(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  rst_n,
   input  logic                  per_frame_vsync,
   input  logic                  per_frame_href,
   input  logic                  per_frame_clken,
   input  logic [DATA_WIDTH-1:0] per_img_data,
   output logic                  post_frame_vsync,
   output logic                  post_frame_href,
   output logic                  post_frame_clken,
   output logic [DATA_WIDTH-1:0] matrix_p11,
   output logic [DATA_WIDTH-1:0] matrix_p12,
   output logic [DATA_WIDTH-1:0] matrix_p13,
   output logic [DATA_WIDTH-1:0] matrix_p21,
   output logic [DATA_WIDTH-1:0] matrix_p22,
   output logic [DATA_WIDTH-1:0] matrix_p23,
   output logic [DATA_WIDTH-1:0] matrix_p31,
   output logic [DATA_WIDTH-1:0] matrix_p32,
   output logic [DATA_WIDTH-1:0] matrix_p33,
   output logic [COORD_W-1:0]    win_x,
   output logic [COORD_W-1:0]    win_y,
   output logic                  win_border,
   output logic                  line_err
);

   localparam logic [COORD_W-1:0] H_MAX  = COORD_W'(H_ACTIVE);
   localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_ACTIVE - 1);
   localparam logic [COORD_W-1:0] V_MAX  = COORD_W'(V_ACTIVE);
   localparam logic [COORD_W-1:0] ONE    = COORD_W'(1);
   localparam logic [COORD_W-1:0] TWO    = COORD_W'(2);

   state_e state_q, state_d;

   logic                  vsync_q, vsync_d;
   logic                  href_q, href_d;
   logic                  post_clken_q, post_clken_d;
   logic [COORD_W-1:0]    col_cnt_q, col_cnt_d;
   logic [COORD_W-1:0]    row_cnt_q, row_cnt_d;
   logic                  line_over_q, line_over_d;
   logic                  line_err_q, line_err_d;
   logic [COORD_W-1:0]    win_x_q, win_x_d;
   logic [COORD_W-1:0]    win_y_q, win_y_d;
   logic                  border_q, border_d;
   logic [2:0][2:0][DATA_WIDTH-1:0] win_q, win_d;

   logic                  vsync_rise, href_rise, href_fall;
   logic                  line_open, pix_strobe, accept, overrun;
   logic                  line_close, len_bad;
   logic [DATA_WIDTH-1:0] tap0_out, tap1_out;

   assign vsync_rise = per_frame_vsync & ~vsync_q;
   assign href_rise  = per_frame_href & ~href_q;
   assign href_fall  = ~per_frame_href & href_q;

   RAMshift_taps #(.Delay_Length(H_ACTIVE), .INPUT_WIDTH(DATA_WIDTH)) u_tap0 (
      .clock    (clock),
      .rst_n    (rst_n),
      .clken    (accept),
      .shiftin  (per_img_data),
      .shiftout (tap0_out)
   );

   RAMshift_taps #(.Delay_Length(H_ACTIVE), .INPUT_WIDTH(DATA_WIDTH)) u_tap1 (
      .clock    (clock),
      .rst_n    (rst_n),
      .clken    (accept),
      .shiftin  (tap0_out),
      .shiftout (tap1_out)
   );

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (vsync_rise) begin
         state_d = WAIT_LINE;
      end else begin
         unique case (state_q)
            IDLE, FRAME_END, ERROR: state_d = state_q;
            WAIT_LINE: begin
               if (row_cnt_q == V_MAX) begin
                  state_d = FRAME_END;
               end else if (href_rise) begin
                  state_d = ACTIVE;
               end
            end
            ACTIVE: begin
               if (href_fall) begin
                  state_d = len_bad ? ERROR : WAIT_LINE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // The first pixel usually arrives with href rising, so WAIT_LINE opens the line in that cycle.
   always_comb begin
      line_open = 1'b0;
      unique case (state_q)
         WAIT_LINE:     line_open = href_rise && (row_cnt_q != V_MAX);
         ACTIVE, ERROR: line_open = 1'b1;
         default:       line_open = 1'b0;
      endcase
      if (vsync_rise) begin
         line_open = 1'b0;
      end
      pix_strobe = line_open && per_frame_href && per_frame_clken;
      accept     = pix_strobe && (col_cnt_q < H_MAX);
      overrun    = pix_strobe && (col_cnt_q >= H_MAX);
      line_close = ((state_q == ACTIVE) || (state_q == ERROR)) && href_fall;
      len_bad    = line_close && ((col_cnt_q != H_MAX) || line_over_q);
   end

   always_comb begin
      vsync_d     = per_frame_vsync;
      href_d      = per_frame_href;
      col_cnt_d   = col_cnt_q;
      row_cnt_d   = row_cnt_q;
      line_over_d = line_over_q;
      line_err_d  = line_err_q;
      if (vsync_rise) begin
         col_cnt_d   = '0;
         row_cnt_d   = '0;
         line_over_d = 1'b0;
         line_err_d  = 1'b0;
      end else begin
         if (accept) begin
            col_cnt_d = col_cnt_q + ONE;
         end
         if (overrun) begin
            line_over_d = 1'b1;
         end
         if (line_close) begin
            col_cnt_d   = '0;
            line_over_d = 1'b0;
            if (row_cnt_q != V_MAX) begin
               row_cnt_d = row_cnt_q + ONE;
            end
            if (len_bad) begin
               line_err_d = 1'b1;
            end
         end
      end
   end

   always_comb begin
      win_d        = win_q;
      win_x_d      = win_x_q;
      win_y_d      = win_y_q;
      border_d     = border_q;
      post_clken_d = accept;
      if (accept) begin
         for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
         end
         win_d[0][2] = tap1_out;
         win_d[1][2] = tap0_out;
         win_d[2][2] = per_img_data;
         win_x_d     = col_cnt_q - ONE;
         win_y_d     = row_cnt_q - ONE;
         border_d    = (col_cnt_q < TWO) || (row_cnt_q < TWO) ||
                       (col_cnt_q == H_LAST) || (state_q == ERROR);
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q      <= 1'b0;
         href_q       <= 1'b0;
         post_clken_q <= 1'b0;
         col_cnt_q    <= '0;
         row_cnt_q    <= '0;
         line_over_q  <= 1'b0;
         line_err_q   <= 1'b0;
         win_x_q      <= '0;
         win_y_q      <= '0;
         border_q     <= 1'b0;
         win_q        <= '0;
      end else begin
         vsync_q      <= vsync_d;
         href_q       <= href_d;
         post_clken_q <= post_clken_d;
         col_cnt_q    <= col_cnt_d;
         row_cnt_q    <= row_cnt_d;
         line_over_q  <= line_over_d;
         line_err_q   <= line_err_d;
         win_x_q      <= win_x_d;
         win_y_q      <= win_y_d;
         border_q     <= border_d;
         win_q        <= win_d;
      end
   end

   assign post_frame_vsync = vsync_q;
   assign post_frame_href  = href_q;
   assign post_frame_clken = post_clken_q;
   assign matrix_p11       = win_q[0][0];
   assign matrix_p12       = win_q[0][1];
   assign matrix_p13       = win_q[0][2];
   assign matrix_p21       = win_q[1][0];
   assign matrix_p22       = win_q[1][1];
   assign matrix_p23       = win_q[1][2];
   assign matrix_p31       = win_q[2][0];
   assign matrix_p32       = win_q[2][1];
   assign matrix_p33       = win_q[2][2];
   assign win_x            = win_x_q;
   assign win_y            = win_y_q;
   assign win_border       = border_q;
   assign line_err         = line_err_q;

endmodule

// File: tb/tb_line_window_ctrl.sv
// Scoreboard bench for line_window_ctrl: a stream-level model of the window
// (last three pixels, each with the pixels H and 2H accepted samples earlier).
module tb_line_window_ctrl;
   import line_window_pkg::*;

   localparam int H  = 8;
   localparam int V  = 4;
   localparam int DW = 8;

   logic          clock = 1'b0;
   logic          rst_n = 1'b0;
   logic          vs = 1'b0, hr = 1'b0, ck = 1'b0;
   logic [DW-1:0] din = '0;

   logic          post_frame_vsync, post_frame_href, post_frame_clken;
   logic [DW-1:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
   logic [15:0]   win_x, win_y;
   logic          win_border, line_err;
   logic [8:0][7:0] obs;

   line_window_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .DATA_WIDTH(DW)) dut (
      .clock(clock), .rst_n(rst_n),
      .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ck), .per_img_data(din),
      .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
      .post_frame_clken(post_frame_clken),
      .matrix_p11(p11), .matrix_p12(p12), .matrix_p13(p13),
      .matrix_p21(p21), .matrix_p22(p22), .matrix_p23(p23),
      .matrix_p31(p31), .matrix_p32(p32), .matrix_p33(p33),
      .win_x(win_x), .win_y(win_y), .win_border(win_border), .line_err(line_err)
   );

   assign obs = {p33, p32, p31, p23, p22, p21, p13, p12, p11};

   always #5 clock = ~clock;

   typedef struct packed {
      logic [8:0][7:0] m;
      logic [8:0]      k;
      logic [15:0]     x;
      logic [15:0]     y;
      logic            b;
      logic [31:0]     cyc;
      logic [1:0]      probe;
   } exp_t;

   exp_t   q[$];
   int     hist[$];
   logic [7:0] mv[3][3];
   bit     mk[3][3];
   bit     frame_on, frame_err;
   int     row_i;
   int     checks = 0, failures = 0;
   int     pulses = 0, acc = 0;
   int     cyc = 0;
   logic   vs_pos = 1'b0, hr_pos = 1'b0, rst_pos = 1'b0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      frame_on  = 1'b0;
      frame_err = 1'b0;
      row_i     = 0;
      for (int c = 0; c < 3; c++)
         for (int r = 0; r < 3; r++) begin
            mv[c][r] = 8'h00;
            mk[c][r] = 1'b1;
         end
   endtask

   // Called in the cycle a pixel is driven; the pulse is due one clock later.
   task automatic model_pixel(input int col, input logic [7:0] d, input logic [1:0] probe);
      exp_t e;
      int   n;
      if (!frame_on || col >= H || (!frame_err && row_i >= V)) return;
      n = hist.size();
      for (int r = 0; r < 3; r++) begin
         mv[0][r] = mv[1][r]; mk[0][r] = mk[1][r];
         mv[1][r] = mv[2][r]; mk[1][r] = mk[2][r];
      end
      mk[2][0] = (n >= 2*H); mv[2][0] = (n >= 2*H) ? 8'(hist[n-2*H]) : 8'h00;
      mk[2][1] = (n >= H);   mv[2][1] = (n >= H)   ? 8'(hist[n-H])   : 8'h00;
      mk[2][2] = 1'b1;       mv[2][2] = d;
      hist.push_back(int'(d));
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) begin
            e.m[r*3+c] = mv[c][r];
            e.k[r*3+c] = mk[c][r];
         end
      e.x     = 16'(col - 1);
      e.y     = 16'(row_i - 1);
      e.b     = (col < 2) || (row_i < 2) || (col == H - 1) || frame_err;
      e.cyc   = 32'(cyc + 1);
      e.probe = probe;
      acc++;
      q.push_back(e);
   endtask

   always @(posedge clock) begin
      cyc++;
      vs_pos  = vs;
      hr_pos  = hr;
      rst_pos = rst_n;
   end

   always @(negedge clock) begin
      exp_t e;
      if (rst_n && rst_pos) begin
         chk("sync_delay", {post_frame_vsync, post_frame_href}, {vs_pos, hr_pos});
      end
      if (post_frame_clken === 1'b1) begin
         pulses++;
         if (q.size() == 0) begin
            chk("unexpected_pulse", 1, 0);
         end else begin
            e = q.pop_front();
            chk("clken_latency", cyc, e.cyc);
            chk("win_x", win_x, e.x);
            chk("win_y", win_y, e.y);
            chk("win_border", win_border, e.b);
            for (int i = 0; i < 9; i++)
               if (e.k[i]) chk($sformatf("p%0d%0d", i/3 + 1, i%3 + 1), obs[i], e.m[i]);
            if (e.probe == 2'd1) begin
               chk("probe_p11", p11, 8'h00);
               chk("probe_p22", p22, 8'h11);
               chk("probe_p33", p33, 8'h22);
               chk("probe_xy", {win_x, win_y}, {16'd1, 16'd1});
               chk("probe_border", win_border, 1'b0);
            end else if (e.probe == 2'd2) begin
               chk("probe_p23", p23, 8'h23);
            end
         end
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_ctl"}, {post_frame_vsync, post_frame_href, post_frame_clken, win_border, line_err}, 0);
      chk({tag, "_matrix"}, obs, 0);
      chk({tag, "_pos"}, {win_x, win_y}, 0);
   endtask

   task automatic do_vsync();
      @(negedge clock);
      vs = 1'b1; hr = 1'b0; ck = 1'b0;
      frame_on = 1'b1; frame_err = 1'b0; row_i = 0;
      repeat (2) @(negedge clock);
      vs = 1'b0;
      repeat (2) @(negedge clock);
   endtask

   // mode 0: continuous clken, 1: every other cycle, 2: random gaps
   task automatic send_line(input int drow, input int npix, input int mode,
                            input int probe_col, input logic [1:0] probe_id);
      int sent  = 0;
      bit phase = 1'b1;
      bit c;
      @(negedge clock);
      hr = 1'b1;
      while (sent < npix) begin
         case (mode)
            0:       c = 1'b1;
            1:       c = phase;
            default: c = ($urandom_range(0, 2) != 0);
         endcase
         phase = ~phase;
         ck = c;
         if (c) begin
            din = 8'(16*drow + sent);
            model_pixel(sent, din, (sent == probe_col) ? probe_id : 2'd0);
            sent++;
         end
         @(negedge clock);
      end
      hr = 1'b0; ck = 1'b0;
      if (frame_on && (frame_err || row_i < V)) begin
         if (npix != H) frame_err = 1'b1;
         row_i++;
      end
      repeat ($urandom_range(1, 3)) @(negedge clock);
   endtask

   task automatic run_frame(input int mode, input int bad_row, input int bad_len, input int nlines,
                            input int probe_row, input int probe_col, input logic [1:0] probe_id,
                            input bit expect32);
      int p0, a0;
      bit prev_err;
      prev_err = (line_err === 1'b1);
      do_vsync();
      if (prev_err) chk("line_err_cleared", line_err, 1'b0);
      chk("state_after_vsync", dut.state_q, WAIT_LINE);
      p0 = pulses; a0 = acc;
      for (int r = 0; r < nlines; r++) begin
         send_line(r, (r == bad_row) ? bad_len : H, mode, (r == probe_row) ? probe_col : -1, probe_id);
         if (r == bad_row) begin
            chk("line_err_set", line_err, 1'b1);
            chk("state_error", dut.state_q, ERROR);
         end
      end
      repeat (3) @(negedge clock);
      if (nlines > V) chk("state_frame_end", dut.state_q, FRAME_END);
      chk("pulse_count", pulses - p0, acc - a0);
      if (expect32) chk("frame_pulses_32", pulses - p0, 32);
      chk("line_err_end", line_err, (bad_row >= 0) ? 1'b1 : 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      model_reset();
      repeat (3) @(negedge clock);
      chk_zero("reset_state");
      chk("reset_fsm", dut.state_q, IDLE);
      rst_n = 1'b1;
      model_reset();

      // Reset mid-frame at row 2, col 3; the partial frame afterwards must be ignored.
      do_vsync();
      send_line(0, H, 0, -1, 2'd0);
      send_line(1, H, 0, -1, 2'd0);
      @(negedge clock);
      hr = 1'b1;
      for (int c = 0; c < 3; c++) begin
         ck = 1'b1; din = 8'(32 + c);
         model_pixel(c, din, 2'd0);
         @(negedge clock);
      end
      ck = 1'b0;
      repeat (3) @(negedge clock);
      chk("drained_before_reset", q.size(), 0);
      rst_n = 1'b0; ck = 1'b1; din = 8'h23;
      model_reset();
      p0 = pulses;
      repeat (2) @(negedge clock);
      chk_zero("mid_reset");
      rst_n = 1'b1;
      for (int c = 3; c < H; c++) begin
         din = 8'(32 + c);
         @(negedge clock);
      end
      hr = 1'b0; ck = 1'b0;
      repeat (2) @(negedge clock);
      send_line(3, H, 0, -1, 2'd0);
      repeat (3) @(negedge clock);
      chk("no_pulses_before_vsync", pulses - p0, 0);
      chk("fsm_idle_after_reset", dut.state_q, IDLE);

      run_frame(0, -1, H, V, 2, 2, 2'd1, 1'b1);
      run_frame(1, -1, H, V, 2, 2, 2'd1, 1'b1);
      run_frame(2, 1, 6, V, -1, 0, 2'd0, 1'b0);
      run_frame(0, 2, 10, V, 3, 3, 2'd2, 1'b0);
      run_frame(0, -1, H, V + 1, -1, 0, 2'd0, 1'b1);
      for (int f = 0; f < 3; f++) begin
         int bad, blen;
         bad  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, V - 1)) : -1;
         blen = ($urandom_range(0, 1) != 0) ? int'($urandom_range(3, H - 1)) : int'($urandom_range(H + 1, H + 3));
         run_frame(int'($urandom_range(0, 2)), bad, blen, V, -1, 0, 2'd0, 1'b0);
      end
      run_frame(2, -1, H, V, -1, 0, 2'd0, 1'b1);

      repeat (5) @(negedge clock);
      chk("scoreboard_empty", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
